// File: rtl/dist_ram_pkg.sv
// Shared widths and word/address types for the 16x4 dual-port distributed RAM.
package dist_ram_pkg;

    localparam int DPR_DATA_W = 4;
    localparam int DPR_ADDR_W = 4;
    localparam int DPR_DEPTH  = 16;

    typedef logic [DPR_DATA_W-1:0] dpr_word_t;
    typedef logic [DPR_ADDR_W-1:0] dpr_addr_t;

endpackage

// File: rtl/dpr_wr_decode.sv
// One-hot write-enable decoder: exactly one strobe per write, none when wre is low.
module dpr_wr_decode
    import dist_ram_pkg::*;
#(
    parameter int ADDR_W = DPR_ADDR_W,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic              wre,
    input  logic [ADDR_W-1:0] wad,
    output logic [DEPTH-1:0]  we_vec
);

    // An unknown wad makes the compare unknown, so no strobe fires and the write is dropped.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_dec
            assign we_vec[gi] = wre & (wad == ADDR_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/dist_ram_16x4_dp.sv
// 16x4 distributed dual-port RAM: synchronous write, combinational read, async active-low clear.
// Define DPR_WR_BYPASS_EN for write-first forwarding of di onto dout on a same-address write.
module dist_ram_16x4_dp
    import dist_ram_pkg::*;
#(
    parameter int                 DATA_W   = DPR_DATA_W,
    parameter int                 ADDR_W   = DPR_ADDR_W,
    parameter logic [DATA_W-1:0]  INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wre,
    input  logic [ADDR_W-1:0] wad,
    input  logic [DATA_W-1:0] di,
    input  logic [ADDR_W-1:0] rad,
    output logic [DATA_W-1:0] dout
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0]  we_vec;
    logic [DATA_W-1:0] mem [DEPTH] = '{default: INIT_VAL};

    dpr_wr_decode #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_wr_decode (
        .wre    (wre),
        .wad    (wad),
        .we_vec (we_vec)
    );

    // The clear holds for as long as rst is low, so writes during reset are lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= INIT_VAL;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (we_vec[i]) begin
                    mem[i] <= di;
                end
            end
        end
    end

    always_comb begin
        dout = mem[rad];
`ifdef DPR_WR_BYPASS_EN
        if (wre && rst && (rad == wad)) begin
            dout = di;
        end
`endif
    end

endmodule

// File: tb/tb_dist_ram_16x4_dp.sv
// Self-checking bench for dist_ram_16x4_dp: table-driven read sweep plus directed corner sequences.
`timescale 1ns/1ps
module tb_dist_ram_16x4_dp;

    logic       clk;
    logic       rst;
    logic       wre;
    logic [3:0] wad;
    logic [3:0] di;
    logic [3:0] rad;
    logic [3:0] dout;

    int n_cmp;
    int n_fail;

    typedef struct {
        logic [3:0] rad;
        logic [3:0] exp;
    } rd_vec_t;

    rd_vec_t sweep [16];

    dist_ram_16x4_dp dut (
        .clk  (clk),
        .rst  (rst),
        .wre  (wre),
        .wad  (wad),
        .di   (di),
        .rad  (rad),
        .dout (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s rad=%0d dout=%h expected=%h", name, rad, act, exp);
        end else begin
            $display("chk  %s rad=%0d dout=%h ok", name, rad, act);
        end
    endtask

    // Drive a write on the falling edge, capture on the next rising edge.
    task automatic do_write(input logic [3:0] a, input logic [3:0] d);
        @(negedge clk);
        wre = 1'b1;
        wad = a;
        di  = d;
        @(posedge clk);
        #1;
        wre = 1'b0;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst = 1'b1;
        wre = 1'b0;
        wad = 4'h0;
        di  = 4'h0;
        rad = 4'h0;

        sweep[0]  = '{4'h0, 4'h5};  sweep[1]  = '{4'h1, 4'h4};
        sweep[2]  = '{4'h2, 4'h7};  sweep[3]  = '{4'h3, 4'h6};
        sweep[4]  = '{4'h4, 4'h1};  sweep[5]  = '{4'h5, 4'h0};
        sweep[6]  = '{4'h6, 4'h3};  sweep[7]  = '{4'h7, 4'h2};
        sweep[8]  = '{4'h8, 4'hD};  sweep[9]  = '{4'h9, 4'hC};
        sweep[10] = '{4'hA, 4'hF};  sweep[11] = '{4'hB, 4'hE};
        sweep[12] = '{4'hC, 4'h9};  sweep[13] = '{4'hD, 4'h8};
        sweep[14] = '{4'hE, 4'hB};  sweep[15] = '{4'hF, 4'hA};

        #1;
        check("init_zero", dout, 4'h0);

        // Reset clears a written word mid-cycle without any clock edge.
        rad = 4'h3;
        do_write(4'h3, 4'hA);
        check("pre_reset_wr", dout, 4'hA);
        @(posedge clk);
        #2;
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rad = 4'(i);
            #1;
            check("reset_clear", dout, 4'h0);
        end
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 16; i++) begin
            do_write(4'(i), 4'(i) ^ 4'h5);
        end
        for (int i = 0; i < 16; i++) begin
            rad = sweep[i].rad;
            #1;
            check("sweep_read", dout, sweep[i].exp);
        end

        // wre low must leave addr 7 untouched.
        @(negedge clk);
        wre = 1'b0;
        wad = 4'h7;
        di  = 4'hF;
        rad = 4'h7;
        repeat (3) @(posedge clk);
        #1;
        check("wre_gate", dout, 4'h2);

        // Same-address read during write.
        do_write(4'h9, 4'h3);
        @(negedge clk);
        rad = 4'h9;
        wre = 1'b1;
        wad = 4'h9;
        di  = 4'hC;
        #1;
`ifdef DPR_WR_BYPASS_EN
        check("collide_pre", dout, 4'hC);
`else
        check("collide_pre", dout, 4'h3);
`endif
        @(posedge clk);
        #1;
        wre = 1'b0;
        check("collide_post", dout, 4'hC);

        // Write port and read port are independent.
        do_write(4'hE, 4'h1);
        @(negedge clk);
        rad = 4'hE;
        wre = 1'b1;
        wad = 4'h2;
        di  = 4'h6;
        #1;
        check("indep_pre", dout, 4'h1);
        @(posedge clk);
        #1;
        wre = 1'b0;
        check("indep_post", dout, 4'h1);
        rad = 4'h2;
        #1;
        check("indep_rd2", dout, 4'h6);

        // Reset asserted on the same edge as a write: mem[5] ends cleared.
        @(negedge clk);
        rad = 4'h5;
        wre = 1'b1;
        wad = 4'h5;
        di  = 4'h9;
        @(posedge clk);
        rst = 1'b0;
        #1;
        check("rst_wr_during", dout, 4'h0);
        @(negedge clk);
        wre = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_wr_after", dout, 4'h0);
        rad = 4'hC;
        #1;
        check("rst_wr_other", dout, 4'h0);

        // Array is writable again after release.
        do_write(4'hC, 4'h7);
        check("post_rst_wr", dout, 4'h7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dist_ram_16x4_dp.md
Name: dist_ram_16x4_dp

Overview:
- 16-word x 4-bit distributed dual-port RAM: one synchronous write port, one asynchronous (combinational) read port.
- Functional equivalent of the vendor 16x4 dual-port distributed-RAM cell.
- Register-file builders tile it, e.g. 8 instances form two 16x8 banks per read port.
- Storage is flops/LUT-RAM inferred from plain RTL, with an added array clear on reset.

Parameters:
- DATA_W, 4, word width in bits.
- ADDR_W, 4, address width; depth = 2**ADDR_W = 16.
- INIT_VAL, 4'h0, value loaded into every word at reset and at time zero.

Ports:
- clk  input  1  write clock; the only clock.
- rst  input  1  asynchronous, active-low reset; clears the whole array.
- wre  input  1  write enable, sampled on rising clk.
- wad  input  ADDR_W  write address.
- di  input  DATA_W  write data.
- rad  input  ADDR_W  read address.
- dout  output  DATA_W  read data, combinational from rad.

Behaviour:
- Storage: mem[0..15], each DATA_W bits. No other state.
- Reset: rst low asynchronously forces every mem[i] = INIT_VAL. This holds while rst is low, and writes are ignored. dout then reads INIT_VAL for any rad.
- Reset deassertion (rst rising) needs no synchronisation inside the block. The first write takes effect on the first rising clk with rst high.
- Simulation start: the array is initialised to INIT_VAL even before any reset pulse.
- Write: on rising clk with rst high and wre=1, mem[wad] <= di. With wre=0, no word changes.
- Write uses a one-hot decode of wad. Exactly one word is written; all others hold.
- Write latency: the new value is visible on dout (when rad==wad) immediately after the capturing edge, in the same delta/cycle.
- Read: dout = mem[rad], purely combinational, zero-cycle latency. dout changes whenever rad or the addressed word changes.
- Same-address read during write (wre=1, rad==wad, before the edge): dout shows the OLD contents until the edge, then the new data. This is the default, no forwarding.
- X/unknown on wad while wre=1: no defined word is corrupted in synthesis. In simulation the write is dropped.
- Address wrap: all 16 addresses are valid; no out-of-range case exists.
- No read enable, no output register, no handshake.

Optional Feature:
- Macro DPR_WR_BYPASS_EN.
- Defined: write-first forwarding. When wre=1, rst=1 and rad==wad, dout = di combinationally in the same cycle, before the edge. Otherwise dout = mem[rad].
- Not defined: read-old-data behaviour as described under Behaviour.
- The array update is identical in both builds.

Decomposition:
- Shared package dist_ram_pkg holds:
  - localparams DPR_DATA_W=4, DPR_ADDR_W=4, DPR_DEPTH=16;
  - typedef dpr_word_t (logic [DATA_W-1:0]);
  - typedef dpr_addr_t (logic [ADDR_W-1:0]).
- One natural sub-module, dpr_wr_decode: ADDR_W-to-DEPTH one-hot write-enable decoder gated by wre.
- Array, reset clear and read mux stay in the top.

Test Plan:
- Reset: write 4'hA to addr 3, then pulse rst low asynchronously mid-cycle. All 16 addresses read 4'h0 immediately, with no clk edge needed.
- Basic write/read: write addr i with data i^4'h5 for i=0..15, then sweep rad 0..15. dout = i^4'h5 at each address, combinationally, with no clock needed for the reads.
- Write enable gating: wre=0, wad=7, di=4'hF, clock 3 edges. Addr 7 is unchanged (still 4'h2 from the previous sweep, i.e. 7^5).
- Same-address collision: mem[9]=4'h3; set wre=1, wad=rad=9, di=4'hC.
  - Without DPR_WR_BYPASS_EN: dout=4'h3 before the edge, 4'hC after.
  - With DPR_WR_BYPASS_EN: dout=4'hC before the edge.
- Independent ports: write addr 2 with 4'h6 while rad=14 holding 4'h1. dout stays 4'h1 across the edge. Then rad=2 gives 4'h6.
- Reset during write: rst low coincident with a clk edge and wre=1, wad=5, di=4'h9. mem[5] reads 4'h0 after the edge, and after rst releases.
